// File: rtl/uart_receiver.sv
`default_nettype none
// uart_receiver: start/M data (LSB first)/stop UART receiver, CLKS_PER_BIT clocks per bit,
// two-flop input synchronizer and mid-bit sampling; one-cycle valid / frame_error strobes.
module uart_receiver #(
  parameter int M            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  output logic [M-1:0] byte_out,
  output logic         valid,
  output logic         frame_error,
  output logic         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(M + 1);

  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          sync_1;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [M-1:0]  shreg;
  logic          start_edge;
  logic          cnt_mid;
  logic          cnt_last;
  logic          take_bit;
  logic          frame_done;

  // Synchronizer and edge history reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_1  <= bit_in;
      rx_s    <= sync_1;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;
  assign cnt_mid    = (cnt == CNT_MID);
  assign cnt_last   = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_edge) begin
          next_state = START;
        end
      end
      START: begin
        if (cnt_mid) begin
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_last && (idx == IDX_LAST)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (cnt_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    take_bit   = (state == DATA) && cnt_last;
    frame_done = (state == STOP) && cnt_last;
  end

  // Counters restart at every phase boundary, so neither runs past its terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      byte_out    <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      valid       <= frame_done && rx_s;
      frame_error <= frame_done && !rx_s;
      if (frame_done && rx_s) begin
        byte_out <= shreg;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
        end
        START: begin
          if (cnt_mid) begin
            cnt <= '0;
            idx <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt   <= '0;
            idx   <= idx + IW'(1);
            shreg <= {rx_s, shreg[M-1:1]};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// tb_uart_receiver: table-driven frames plus hand sequences, checked against a scoreboard of
// expected strobes (kind, byte, latency from line fall).
module tb_uart_receiver;

  localparam int M   = 8;
  localparam int CPB = 4;
  localparam int LAT = 2 + CPB / 2 + (M + 1) * CPB + 1;

  typedef struct {
    logic         err;
    logic [M-1:0] data;
    int           fall;
  } exp_t;

  typedef struct {
    logic [M-1:0] data;
    logic         stop;
    int           gap;
    logic [M-1:0] exp_byte;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bit_in = 1'b1;
  logic [M-1:0] byte_out;
  logic         valid;
  logic         frame_error;
  logic         busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic prev_busy = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;

  uart_receiver #(.M(M), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .byte_out    (byte_out),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [M-1:0] d, input logic stop, input logic [M-1:0] exp_byte);
    exp_t e;
    e.err  = !stop;
    e.data = exp_byte;
    e.fall = cyc;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < M; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // Every strobe is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && (valid || frame_error)) begin
      chk("valid_and_error_exclusive", valid & frame_error, 0);
      chk("pulse_width_one", prev_valid | prev_err, 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {valid, frame_error}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_kind_valid", valid, !e.err);
        chk("strobe_kind_error", frame_error, e.err);
        chk("byte_out", byte_out, e.data);
        chk("latency_from_fall", cyc - e.fall, LAT);
        chk("busy_low_with_strobe", busy, 0);
        chk("busy_high_before_strobe", prev_busy, 1);
      end
    end
    prev_busy  = busy;
    prev_valid = valid;
    prev_err   = frame_error;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[6];
    logic         saw_busy;
    logic [M+1:0] fr;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 6, exp_byte: 8'hA5};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_byte: 8'h00};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 6, exp_byte: 8'hFF};
    vecs[3] = '{data: 8'h01, stop: 1'b1, gap: 3, exp_byte: 8'h01};
    vecs[4] = '{data: 8'h80, stop: 1'b1, gap: 0, exp_byte: 8'h80};
    vecs[5] = '{data: 8'h6E, stop: 1'b1, gap: 6, exp_byte: 8'h6E};

    reset  = 1'b1;
    bit_in = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(20);
    chk("reset_valid", valid, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_busy", busy, 0);
    chk("reset_byte_out", byte_out, 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].exp_byte);
      bit_in = 1'b1;
      tick(vecs[v].gap);
    end
    wait_drain();
    tick(4);

    // One-clock glitch on an idle line.
    saw_busy = 1'b0;
    bit_in   = 1'b0;
    tick(1);
    bit_in = 1'b1;
    for (int i = 0; i < CPB / 2 + 3; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    @(posedge clk);
    #1;
    chk("glitch_busy_pulsed", saw_busy, 1);
    chk("glitch_back_to_idle", busy, 0);
    tick(10);

    // Bad stop bit, line then held low: no restart until a fresh falling edge.
    send_frame(8'h3C, 1'b0, 8'h6E);
    tick(20);
    chk("low_line_no_start", busy, 0);
    chk("byte_out_kept_after_error", byte_out, 8'h6E);
    bit_in = 1'b1;
    tick(8);
    chk("high_line_no_start", busy, 0);
    send_frame(8'h81, 1'b1, 8'h81);
    bit_in = 1'b1;
    wait_drain();
    tick(4);

    // Reset 15 clocks into a frame, held until the frame's bits have gone by.
    fr = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < (M + 2) * CPB; c++) begin
      bit_in = fr[c / CPB];
      if (c == 14) chk("busy_before_reset", busy, 1);
      if (c == 15) reset = 1'b1;
      if (c == 16) begin
        chk("busy_after_reset", busy, 0);
        chk("byte_out_after_reset", byte_out, 0);
      end
      tick(1);
    end
    bit_in = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("idle_after_reset_release", busy, 0);
    send_frame(8'h5A, 1'b1, 8'h5A);
    bit_in = 1'b1;
    wait_drain();
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
